// File: rtl/pulse_stretch.sv
// pulse_stretch
//   Output-side pulse conditioner. Turns short or chattering requests on
//   `in` into clean pulses. Every high phase of `out` lasts at least OnTime
//   clk cycles. Every low phase that follows a high phase lasts at least
//   OffTime clk cycles. A request held longer than OnTime extends the high
//   phase for as long as it stays asserted.
//
//   Parameters
//     Bits    : width of the internal hold counter
//     OnTime  : minimum high time of out, 1 .. 2^Bits-1
//     OffTime : minimum low time of out after a high phase, 1 .. 2^Bits-1
//
//   Ports
//     clk   : rising-edge clock
//     reset : synchronous, active-high reset
//     in    : request, level or single-cycle pulse
//     out   : stretched output, registered
//     busy  : high whenever the FSM is not idle, decoded from the state register
//
//   Optional feature (macro PULSE_STRETCH_PENDING_EN)
//     When defined, a request seen at any point during the off hold-off is
//     remembered in a one-bit pending flag and serviced when the hold-off
//     ends. When undefined, only a request present on the final hold-off
//     edge re-triggers the output; earlier requests are dropped.

module pulse_stretch #(
  parameter int Bits    = 4,
  parameter int OnTime  = 4,
  parameter int OffTime = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ON_MIN  = 2'd1,
    ON_EXT  = 2'd2,
    OFF_MIN = 2'd3
  } state_t;

  // Counter load values. Both are strictly below 2^Bits, so the counter
  // never needs more than Bits bits and never wraps.
  localparam logic [Bits-1:0] OnLoad  = Bits'(OnTime - 1);
  localparam logic [Bits-1:0] OffLoad = Bits'(OffTime - 1);
  localparam logic [Bits-1:0] CountOne = Bits'(1);

  // Reject parameter values the counter cannot represent.
  if (OnTime < 1 || OnTime > (2 ** Bits) - 1) begin : g_bad_on_time
    $error("pulse_stretch: OnTime out of range 1..2^Bits-1");
  end
  if (OffTime < 1 || OffTime > (2 ** Bits) - 1) begin : g_bad_off_time
    $error("pulse_stretch: OffTime out of range 1..2^Bits-1");
  end

  state_t          state_q, state_d;
  logic [Bits-1:0] count_q, count_d;
  logic            out_q, out_d;
  logic            retrigger;

`ifdef PULSE_STRETCH_PENDING_EN
  logic            pending_q, pending_d;

  // A request seen anywhere in the hold-off, or on its last edge, restarts
  // the output once the minimum off time has elapsed.
  assign retrigger = in | pending_q;
`else
  // Only a request still present on the last hold-off edge restarts the
  // output.
  assign retrigger = in;
`endif

  // State, counter and output registers. Reset aborts any phase at once;
  // there is no minimum off time after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      out_q     <= 1'b0;
`ifdef PULSE_STRETCH_PENDING_EN
      pending_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      out_q     <= out_d;
`ifdef PULSE_STRETCH_PENDING_EN
      pending_q <= pending_d;
`endif
    end
  end

  // Next-state logic. The counter holds the remaining cycles of the current
  // minimum phase; a phase may only end on the edge where it reads zero.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    out_d     = out_q;
`ifdef PULSE_STRETCH_PENDING_EN
    pending_d = pending_q;
`endif

    case (state_q)
      IDLE: begin
        if (in) begin
          state_d = ON_MIN;
          out_d   = 1'b1;
          count_d = OnLoad;
        end
      end

      ON_MIN: begin
        if (count_q != '0) begin
          count_d = count_q - CountOne;
        end else if (in) begin
          state_d = ON_EXT;
        end else begin
          state_d = OFF_MIN;
          out_d   = 1'b0;
          count_d = OffLoad;
        end
      end

      // Stay high for as long as the request is held.
      ON_EXT: begin
        if (!in) begin
          state_d = OFF_MIN;
          out_d   = 1'b0;
          count_d = OffLoad;
        end
      end

      OFF_MIN: begin
        if (count_q != '0) begin
          count_d = count_q - CountOne;
`ifdef PULSE_STRETCH_PENDING_EN
          pending_d = pending_q | in;
`endif
        end else if (retrigger) begin
          state_d = ON_MIN;
          out_d   = 1'b1;
          count_d = OnLoad;
`ifdef PULSE_STRETCH_PENDING_EN
          pending_d = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        out_d   = 1'b0;
        count_d = '0;
      end
    endcase
  end

  assign out  = out_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch
//   Directed bench for pulse_stretch. Three instances share clk and reset:
//   dut_a (OnTime=4, OffTime=3) carries the main scenarios, dut_b
//   (OnTime=1, OffTime=1) the shortest timing, dut_c (OnTime=15,
//   OffTime=15) the full counter range for Bits=4.

module tb_pulse_stretch;

  logic clk = 1'b0;
  logic reset;
  logic in_a, in_b, in_c;
  logic out_a, out_b, out_c;
  logic busy_a, busy_b, busy_c;

  int total = 0;
  int bad   = 0;

  pulse_stretch #(.Bits(4), .OnTime(4), .OffTime(3)) dut_a (
    .clk(clk), .reset(reset), .in(in_a), .out(out_a), .busy(busy_a)
  );

  pulse_stretch #(.Bits(4), .OnTime(1), .OffTime(1)) dut_b (
    .clk(clk), .reset(reset), .in(in_b), .out(out_b), .busy(busy_b)
  );

  pulse_stretch #(.Bits(4), .OnTime(15), .OffTime(15)) dut_c (
    .clk(clk), .reset(reset), .in(in_c), .out(out_c), .busy(busy_c)
  );

  always #5 clk = ~clk;

  // Drive all inputs, then advance one rising edge and settle 1 time unit
  // past it so outputs are sampled away from the edge.
  task automatic applyStimulus(input logic rst, input logic a,
                               input logic b, input logic c);
    reset = rst;
    in_a  = a;
    in_b  = b;
    in_c  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic observed,
                             input logic expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_a  = 1'b0;
    in_b  = 1'b0;
    in_c  = 1'b0;
    #1;

    // Scenario 1: reset held three cycles while in toggles.
    $display("[TB] scenario 1: reset priority");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst0_out", out_a, 1'b0);
    checkOutput("rst0_busy", busy_a, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rst1_out", out_a, 1'b0);
    checkOutput("rst1_busy", busy_a, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst2_out", out_a, 1'b0);
    checkOutput("rst2_busy", busy_a, 1'b0);
    checkOutput("rst2_out_b", out_b, 1'b0);
    checkOutput("rst2_out_c", out_c, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("post_rst_out", out_a, 1'b1);
    checkOutput("post_rst_busy", busy_a, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Scenario 2: single-cycle request gives exactly 4 high, 3 low cycles.
    $display("[TB] scenario 2: single pulse");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("s2_k_out", out_a, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("s2_k+%0d_out", i), out_a, 1'b1);
    end
    for (int i = 4; i <= 6; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("s2_k+%0d_out", i), out_a, 1'b0);
      checkOutput($sformatf("s2_k+%0d_busy", i), busy_a, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s2_k+7_busy", busy_a, 1'b0);
    checkOutput("s2_k+7_out", out_a, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("s2_k+8_out", out_a, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Scenario 3: request held 10 cycles extends the high phase.
    $display("[TB] scenario 3: extended request");
    for (int i = 0; i <= 9; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("s3_k+%0d_out", i), out_a, 1'b1);
    end
    for (int i = 10; i <= 12; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("s3_k+%0d_out", i), out_a, 1'b0);
      checkOutput($sformatf("s3_k+%0d_busy", i), busy_a, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s3_k+13_busy", busy_a, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Scenario 4: second pulse lands inside the off hold-off at k+5.
    $display("[TB] scenario 4: request during hold-off");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("s4_k+4_out", out_a, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("s4_k+5_out", out_a, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s4_k+6_out", out_a, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PULSE_STRETCH_PENDING_EN
    checkOutput("s4_k+7_out", out_a, 1'b1);
    checkOutput("s4_k+7_busy", busy_a, 1'b1);
    for (int i = 8; i <= 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("s4_k+%0d_out", i), out_a, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s4_k+11_out", out_a, 1'b0);
`else
    checkOutput("s4_k+7_out", out_a, 1'b0);
    checkOutput("s4_k+7_busy", busy_a, 1'b0);
`endif
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Scenario 5: reset in the middle of an extended high phase.
    $display("[TB] scenario 5: reset during ON_EXT");
    for (int i = 0; i <= 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("s5_k+5_out", out_a, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("s5_k+6_out", out_a, 1'b0);
    checkOutput("s5_k+6_busy", busy_a, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("s5_k+7_out", out_a, 1'b1);
    checkOutput("s5_k+7_busy", busy_a, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Scenario 6a: OnTime=1, OffTime=1 with alternating requests.
    $display("[TB] scenario 6a: one-cycle minimums");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("s6a_e0_out", out_b, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s6a_e1_out", out_b, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("s6a_e2_out", out_b, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s6a_e3_out", out_b, 1'b0);
    checkOutput("s6a_e3_busy", busy_b, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s6a_e4_busy", busy_b, 1'b0);

    // Scenario 6b: OnTime=15, OffTime=15 exercises the full counter range.
    $display("[TB] scenario 6b: maximum counts");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("s6b_k_out", out_c, 1'b1);
    for (int i = 1; i <= 14; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("s6b_k+%0d_out", i), out_c, 1'b1);
    end
    for (int i = 15; i <= 29; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("s6b_k+%0d_out", i), out_c, 1'b0);
      checkOutput($sformatf("s6b_k+%0d_busy", i), busy_c, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s6b_k+30_busy", busy_c, 1'b0);
    checkOutput("s6b_k+30_out", out_c, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
